// File: rtl/alu_mul_seq_if.sv
// Bundle between the shift-add multiplier controller, its requester and the shared ALU.
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             Start;
  logic [WIDTH-1:0] MulA;
  logic [WIDTH-1:0] MulB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Product;
  logic [WIDTH-1:0] AluA;
  logic [WIDTH-1:0] AluB;
  logic [3:0]       AluCtrl;
  logic [WIDTH-1:0] AluW;

  modport master (
    output Start, MulA, MulB, AluW,
    input  Busy, Done, Product, AluA, AluB, AluCtrl
  );

  modport slave (
    input  Start, MulA, MulB, AluW,
    output Busy, Done, Product, AluA, AluB, AluCtrl
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier that borrows an external ALU in ADD mode,
// one partial-product accumulation per clock.
module alu_mul_seq #(
  parameter int unsigned WIDTH      = 64,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset_L,
  alu_mul_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [3:0]  AluAdd = 4'h2;
  localparam logic [3:0]  AluNop = 4'h0;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= StIdle;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          m_d     = bus.MulA;
          q_d     = bus.MulB;
          p_d     = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (q_q[0]) begin
          p_d = bus.AluW;
        end
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Publish on the exit edge so Product already includes this cycle's add.
        if ((cnt_q == CW'(WIDTH - 1)) || (EARLY_EXIT && (q_d == '0))) begin
          product_d = p_d;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.Busy    = (state_q == StRun);
  assign bus.Done    = (state_q == StDone);
  assign bus.Product = product_q;
  assign bus.AluA    = p_q;
  assign bus.AluB    = m_q;
  assign bus.AluCtrl = (state_q == StRun) ? AluAdd : AluNop;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed scoreboard bench for alu_mul_seq with early exit enabled (dut 1) and disabled (dut 0).
module tb_alu_mul_seq;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic [63:0] prod;
    logic [31:0] n;
  } exp_t;

  logic Clk;
  logic Reset_L;

  alu_mul_seq_if #(.WIDTH(W)) if0 ();
  alu_mul_seq_if #(.WIDTH(W)) if1 ();

  // Stand-in for the external ALU in ADD mode.
  assign if0.AluW = if0.AluA + if0.AluB;
  assign if1.AluW = if1.AluA + if1.AluB;

  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
    .Clk     (Clk),
    .Reset_L (Reset_L),
    .bus     (if0)
  );

  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
    .Clk     (Clk),
    .Reset_L (Reset_L),
    .bus     (if1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int   busy_cnt[2];
  int   done_cnt[2];
  logic done_prev[2];
  logic busy_s[2];
  logic done_s[2];
  logic [3:0]  ctrl_s[2];
  logic [63:0] prod_s[2];

  assign busy_s[0] = if0.Busy;
  assign busy_s[1] = if1.Busy;
  assign done_s[0] = if0.Done;
  assign done_s[1] = if1.Done;
  assign ctrl_s[0] = if0.AluCtrl;
  assign ctrl_s[1] = if1.AluCtrl;
  assign prod_s[0] = if0.Product;
  assign prod_s[1] = if1.Product;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every Done pulse.
  always @(negedge Clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!Reset_L) begin
        busy_cnt[s]  = 0;
        done_prev[s] = 1'b0;
      end else begin
        if (busy_s[s]) begin
          busy_cnt[s]++;
          check($sformatf("aluctrl_run%0d", s), 64'(ctrl_s[s]), 64'h2);
        end
        if (done_s[s]) begin
          exp_t e;
          check($sformatf("done_single%0d", s), 64'(done_prev[s]), 64'h0);
          check($sformatf("busy_in_done%0d", s), 64'(busy_s[s]), 64'h0);
          check($sformatf("aluctrl_done%0d", s), 64'(ctrl_s[s]), 64'h0);
          if ((s == 0 && sb0.size() == 0) || (s == 1 && sb1.size() == 0)) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow%0d: observed=unexpected Done expected=no Done", s);
          end else begin
            e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("product%0d", s), prod_s[s], e.prod);
            check($sformatf("busy_len%0d", s), 64'(busy_cnt[s]), 64'(e.n));
          end
          busy_cnt[s] = 0;
          done_cnt[s]++;
        end
        done_prev[s] = done_s[s];
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic [63:0] a, input logic [63:0] b);
    if (sel == 0) begin
      if0.Start = st; if0.MulA = a; if0.MulB = b;
    end else begin
      if1.Start = st; if1.MulA = a; if1.MulB = b;
    end
  endtask

  task automatic wait_done(input int sel, input int target);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt[sel] >= target) break;
      step();
    end
    check($sformatf("done_seen%0d", sel), 64'(done_cnt[sel] >= target), 64'h1);
  endtask

  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] prod, input int n);
    int target;
    target = done_cnt[sel] + 1;
    if (sel == 0) sb0.push_back('{prod: prod, n: 32'(n)});
    else          sb1.push_back('{prod: prod, n: 32'(n)});
    drive(sel, 1'b1, a, b);
    step();
    drive(sel, 1'b0, 64'hDEAD_BEEF, 64'hFFFF_FFFF);
    wait_done(sel, target);
    step();
  endtask

  initial begin
    int base;
    Reset_L = 1'b0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    step();
    step();
    check("rst_busy", 64'(if1.Busy), 64'h0);
    check("rst_done", 64'(if1.Done), 64'h0);
    check("rst_product", if1.Product, 64'h0);
    check("rst_aluctrl", 64'(if1.AluCtrl), 64'h0);
    check("rst_alua", if1.AluA, 64'h0);
    check("rst_alub", if1.AluB, 64'h0);
    Reset_L = 1'b1;
    step();

    // Basic, zero multiplier, and wrap cases with early exit.
    run_op(1, 64'd3, 64'd5, 64'hF, 3);
    check("idle_aluctrl", 64'(if1.AluCtrl), 64'h0);
    run_op(1, 64'h1234, 64'h0, 64'h0, 1);
    run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    run_op(1, 64'h8000_0000_0000_0000, 64'd2, 64'h0, 2);

    // Full-length run without early exit.
    run_op(0, 64'h1234, 64'hABCD_0000, 64'h0C37_4FA4_0000, 64);

    // Start re-pulsed while busy and held through Done.
    base = done_cnt[1];
    sb1.push_back('{prod: 64'h800, n: 32'd8});
    sb1.push_back('{prod: 64'd35, n: 32'd3});
    drive(1, 1'b1, 64'h10, 64'h80);
    step();
    drive(1, 1'b0, 64'h10, 64'h80);
    step();
    step();
    drive(1, 1'b1, 64'd5, 64'd7);
    wait_done(1, base + 1);
    step();
    drive(1, 1'b0, 64'd5, 64'd7);
    wait_done(1, base + 2);
    step();
    check("held_product", if1.Product, 64'd35);

    // Asynchronous reset between edges in the middle of a run.
    base = done_cnt[1];
    drive(1, 1'b1, 64'd3, 64'hFF);
    step();
    drive(1, 1'b0, 64'd3, 64'hFF);
    step();
    step();
    check("mid_busy_before_rst", 64'(if1.Busy), 64'h1);
    #2;
    Reset_L = 1'b0;
    #1;
    check("arst_busy", 64'(if1.Busy), 64'h0);
    check("arst_done", 64'(if1.Done), 64'h0);
    check("arst_product", if1.Product, 64'h0);
    step();
    Reset_L = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_idle", 64'(if1.Busy), 64'h0);
    check("post_rst_no_done", 64'(done_cnt[1]), 64'(base));
    run_op(1, 64'd7, 64'd6, 64'd42, 3);

    check("sb1_drained", 64'(sb1.size()), 64'h0);
    check("sb0_drained", 64'(sb0.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
